// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite crossbar control slice.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE
    } arb_state_t;

    typedef enum logic {
        DIR_READ,
        DIR_WRITE
    } txn_dir_t;

endpackage

// File: rtl/axi_lite_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module axi_lite_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan from ptr upward; the first hit wins and later hits are ignored.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!gnt_any && req[PW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_lite_arbiter_ctrl.sv
// Transaction scheduler for the AXI4-Lite crossbar: round-robin master pick,
// slave address decode, grant hold until response or watchdog expiry.
module axi_lite_arbiter_ctrl
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_MASTER  = 2,
    parameter int unsigned NUM_SLAVE   = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [NUM_SLAVE*ADDR_W-1:0] SLV_BASE  = {32'h10, 32'h0},
    parameter logic [NUM_SLAVE*ADDR_W-1:0] SLV_LIMIT = {32'h20, 32'h10},
    parameter int unsigned TIMEOUT_CYC = 256,
    localparam int unsigned MW  = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1,
    localparam int unsigned SW  = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1,
    localparam int unsigned WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_MASTER-1:0]        m_arvalid,
    input  logic [NUM_MASTER-1:0]        m_awvalid,
    input  logic [NUM_MASTER*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTER*ADDR_W-1:0] m_awaddr,
    input  logic                         r_done,
    input  logic                         b_done,
    output logic                         grant_valid,
    output logic                         grant_is_write,
    output logic [MW-1:0]                sel_m,
    output logic [SW-1:0]                sel_s,
    output logic                         decode_err,
    output logic                         timeout_err,
    output logic                         busy
);

    arb_state_t      state_q, state_d;
    txn_dir_t        rw_pref_q, rw_pref_d;
    logic [MW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
    logic            grant_valid_q, grant_valid_d;
    logic            grant_is_write_q, grant_is_write_d;
    logic [MW-1:0]   sel_m_q, sel_m_d;
    logic [SW-1:0]   sel_s_q, sel_s_d;
    logic            decode_err_q, decode_err_d;
    logic            timeout_err_q, timeout_err_d;

    logic [NUM_MASTER-1:0] req;
    logic [MW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  win_ar, win_aw;
    logic [ADDR_W-1:0]     win_araddr, win_awaddr;
    logic                  take_wr, done, expire;
    logic [SW:0]           dec;

    // Returns {miss, slave_index}; the lowest matching slave wins.
    function automatic logic [SW:0] addr_decode(input logic [ADDR_W-1:0] addr);
        logic          hit;
        logic [SW-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVE; i++) begin
            if (!hit && addr >= SLV_BASE[i*ADDR_W +: ADDR_W]
                     && addr <  SLV_LIMIT[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = SW'(i);
            end
        end
        return {~hit, idx};
    endfunction

    assign req = m_arvalid | m_awvalid;

    axi_lite_rr_pick #(
        .N  (NUM_MASTER),
        .PW (MW)
    ) u_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Route the picked master's valids and addresses to the decode path.
    always_comb begin
        win_ar     = 1'b0;
        win_aw     = 1'b0;
        win_araddr = '0;
        win_awaddr = '0;
        for (int unsigned i = 0; i < NUM_MASTER; i++) begin
            if (MW'(i) == pick_idx) begin
                win_ar     = m_arvalid[i];
                win_aw     = m_awvalid[i];
                win_araddr = m_araddr[i*ADDR_W +: ADDR_W];
                win_awaddr = m_awaddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state logic: grant capture in IDLE, completion or watchdog expiry when granted.
    always_comb begin
        state_d          = state_q;
        rw_pref_d        = rw_pref_q;
        rr_ptr_d         = rr_ptr_q;
        wd_cnt_d         = wd_cnt_q;
        grant_valid_d    = grant_valid_q;
        grant_is_write_d = grant_is_write_q;
        sel_m_d          = sel_m_q;
        sel_s_d          = sel_s_q;
        decode_err_d     = decode_err_q;
        timeout_err_d    = 1'b0;
        take_wr          = win_aw & (~win_ar | (rw_pref_q == DIR_WRITE));
        dec              = addr_decode(take_wr ? win_awaddr : win_araddr);
        done             = (state_q == ARB_READ) ? r_done : b_done;
        expire           = (TIMEOUT_CYC != 0) && (wd_cnt_q == WDW'(TIMEOUT_CYC - 1));

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d          = take_wr ? ARB_WRITE : ARB_READ;
                    grant_valid_d    = 1'b1;
                    grant_is_write_d = take_wr;
                    sel_m_d          = pick_idx;
                    sel_s_d          = dec[SW-1:0];
                    decode_err_d     = dec[SW];
                    wd_cnt_d         = '0;
                end
            end
            ARB_READ, ARB_WRITE: begin
                if (done || expire) begin
                    // Expiry shares the normal completion path; done takes priority.
                    timeout_err_d = ~done;
                    state_d       = ARB_IDLE;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = (sel_m_q == MW'(NUM_MASTER - 1)) ? '0 : sel_m_q + MW'(1);
                    rw_pref_d     = (state_q == ARB_READ) ? DIR_WRITE : DIR_READ;
                end else begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q          <= ARB_IDLE;
            rw_pref_q        <= DIR_READ;
            rr_ptr_q         <= '0;
            wd_cnt_q         <= '0;
            grant_valid_q    <= 1'b0;
            grant_is_write_q <= 1'b0;
            sel_m_q          <= '0;
            sel_s_q          <= '0;
            decode_err_q     <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            rw_pref_q        <= rw_pref_d;
            rr_ptr_q         <= rr_ptr_d;
            wd_cnt_q         <= wd_cnt_d;
            grant_valid_q    <= grant_valid_d;
            grant_is_write_q <= grant_is_write_d;
            sel_m_q          <= sel_m_d;
            sel_s_q          <= sel_s_d;
            decode_err_q     <= decode_err_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign grant_valid    = grant_valid_q;
    assign grant_is_write = grant_is_write_q;
    assign sel_m          = sel_m_q;
    assign sel_s          = sel_s_q;
    assign decode_err     = decode_err_q;
    assign timeout_err    = timeout_err_q;
    assign busy           = (state_q != ARB_IDLE);

endmodule
